// File: rtl/dma_axi64_engine.sv
// Single-channel memory-to-memory DMA: 64-bit AXI3 master, 32-bit APB register slave.
// Define DMA_AXI64_PERIPH_HS_EN to build in the per-burst peripheral handshake states.
module dma_axi64_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        scan_en,
  output logic        idle,
  output logic        INT,
  input  logic        periph_tx_req,
  output logic        periph_tx_clr,
  input  logic        periph_rx_req,
  output logic        periph_rx_clr,
  input  logic        pclken,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic        pready,
  output logic [3:0]  AWID0,
  output logic [31:0] AWADDR0,
  output logic [3:0]  AWLEN0,
  output logic [1:0]  AWSIZE0,
  output logic        AWVALID0,
  input  logic        AWREADY0,
  output logic [3:0]  WID0,
  output logic [63:0] WDATA0,
  output logic [7:0]  WSTRB0,
  output logic        WLAST0,
  output logic        WVALID0,
  input  logic        WREADY0,
  input  logic [3:0]  BID0,
  input  logic [1:0]  BRESP0,
  input  logic        BVALID0,
  output logic        BREADY0,
  output logic [3:0]  ARID0,
  output logic [31:0] ARADDR0,
  output logic [3:0]  ARLEN0,
  output logic [1:0]  ARSIZE0,
  output logic        ARVALID0,
  input  logic        ARREADY0,
  input  logic [3:0]  RID0,
  input  logic [63:0] RDATA0,
  input  logic [1:0]  RRESP0,
  input  logic        RLAST0,
  input  logic        RVALID0,
  output logic        RREADY0
);
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0, ST_RD_HS = 3'd1, ST_AR = 3'd2, ST_R = 3'd3,
    ST_WR_HS = 3'd4, ST_AW = 3'd5, ST_W = 3'd6, ST_B = 3'd7
  } state_t;

  state_t      state_r, state_s, rd_entry_s, wr_entry_s;
  logic [31:0] src_r, dst_r, cur_src_r, cur_dst_r;
  logic [15:0] len_r, rem_r, rem_next_s, step_s;
  logic        int_en_r, done_r, err_r, err_pend_r, rd_hs_s, wr_hs_s;
  logic [3:0]  blen_r, blen_s, cnt_r;
  logic [4:0]  beats_s, beats_m1_s;
  logic [9:0]  src_room_s, dst_room_s;
  logic [12:0] rem_beats_s;
  logic [63:0] buf_r [16];
  logic        apb_acc_s, apb_wr_s, busy_s, start_req_s, unmapped_s;
  logic        sel_src_s, sel_dst_s, sel_len_s, sel_ctrl_s, sel_stat_s;
  logic        ar_hs_s, r_beat_s, r_last_s, w_beat_s, b_hs_s, r_err_s;
  logic        periph_rx_clr_r, periph_tx_clr_r, unused_s;

  assign apb_acc_s   = psel & penable & pclken;
  assign apb_wr_s    = apb_acc_s & pwrite;
  assign sel_src_s   = (paddr == 8'h00);
  assign sel_dst_s   = (paddr == 8'h04);
  assign sel_len_s   = (paddr == 8'h08);
  assign sel_ctrl_s  = (paddr == 8'h0C);
  assign sel_stat_s  = (paddr == 8'h10);
  assign busy_s      = (state_r != ST_IDLE);
  assign start_req_s = apb_wr_s & sel_ctrl_s & pwdata[0] & ~busy_s;
  assign r_err_s     = err_pend_r | (RRESP0 != 2'b00);
  assign unused_s    = ^{scan_en, RLAST0, RID0, BID0, beats_m1_s[4]};

`ifdef DMA_AXI64_PERIPH_HS_EN
  logic rd_hs_r, wr_hs_r;
  // Handshake enables, writable at any time like int_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_hs_r <= 1'b0;
      wr_hs_r <= 1'b0;
    end else if (apb_wr_s && sel_ctrl_s) begin
      rd_hs_r <= pwdata[2];
      wr_hs_r <= pwdata[3];
    end
  end
  assign rd_hs_s    = rd_hs_r;
  assign wr_hs_s    = wr_hs_r;
  assign rd_entry_s = rd_hs_r ? ST_RD_HS : ST_AR;
  assign wr_entry_s = wr_hs_r ? ST_WR_HS : ST_AW;
`else
  assign rd_hs_s    = 1'b0;
  assign wr_hs_s    = 1'b0;
  assign rd_entry_s = ST_AR;
  assign wr_entry_s = ST_AW;
`endif

  // Burst sizing: smallest of 16 beats, remaining bytes, and room to each 4 KB boundary.
  always_comb begin
    rem_beats_s = rem_r[15:3];
    src_room_s  = 10'd512 - {1'b0, cur_src_r[11:3]};
    dst_room_s  = 10'd512 - {1'b0, cur_dst_r[11:3]};
    beats_s     = (rem_beats_s < 13'd16) ? rem_beats_s[4:0] : 5'd16;
    beats_s     = (src_room_s < {5'd0, beats_s}) ? src_room_s[4:0] : beats_s;
    beats_s     = (dst_room_s < {5'd0, beats_s}) ? dst_room_s[4:0] : beats_s;
    beats_m1_s  = beats_s - 5'd1;
    blen_s      = beats_m1_s[3:0];
    step_s      = {8'd0, {1'b0, blen_r} + 5'd1, 3'b000};
    rem_next_s  = rem_r - step_s;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Next-state decode and per-channel handshake strobes.
  always_comb begin
    state_s  = state_r;
    ar_hs_s  = 1'b0;
    r_beat_s = 1'b0;
    r_last_s = 1'b0;
    w_beat_s = 1'b0;
    b_hs_s   = 1'b0;
    case (state_r)
      ST_IDLE:  if (start_req_s && (len_r != 16'd0)) state_s = rd_entry_s; else state_s = ST_IDLE;
      ST_RD_HS: if (periph_rx_req) state_s = ST_AR; else state_s = ST_RD_HS;
      ST_AR: begin
        if (ARREADY0) begin
          ar_hs_s = 1'b1;
          state_s = ST_R;
        end else begin
          state_s = ST_AR;
        end
      end
      ST_R: begin
        if (RVALID0) begin
          r_beat_s = 1'b1;
          if (cnt_r == blen_r) begin
            r_last_s = 1'b1;
            state_s  = r_err_s ? ST_IDLE : wr_entry_s;
          end else begin
            state_s  = ST_R;
          end
        end else begin
          state_s = ST_R;
        end
      end
      ST_WR_HS: if (periph_tx_req) state_s = ST_AW; else state_s = ST_WR_HS;
      ST_AW:    if (AWREADY0) state_s = ST_W; else state_s = ST_AW;
      ST_W: begin
        if (WREADY0) begin
          w_beat_s = 1'b1;
          state_s  = (cnt_r == blen_r) ? ST_B : ST_W;
        end else begin
          state_s  = ST_W;
        end
      end
      ST_B: begin
        if (BVALID0) begin
          b_hs_s = 1'b1;
          if (BRESP0 != 2'b00)           state_s = ST_IDLE;
          else if (rem_next_s == 16'd0)  state_s = ST_IDLE;
          else                           state_s = rd_entry_s;
        end else begin
          state_s = ST_B;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Programmed registers, transfer progress and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_r <= 32'd0;  dst_r <= 32'd0;  len_r <= 16'd0;
      cur_src_r <= 32'd0;  cur_dst_r <= 32'd0;  rem_r <= 16'd0;
      int_en_r <= 1'b0;  done_r <= 1'b0;  err_r <= 1'b0;  err_pend_r <= 1'b0;
      blen_r <= 4'd0;  cnt_r <= 4'd0;
      periph_rx_clr_r <= 1'b0;  periph_tx_clr_r <= 1'b0;
    end else begin
      periph_rx_clr_r <= 1'b0;
      periph_tx_clr_r <= 1'b0;
      if (apb_wr_s && !busy_s && sel_src_s) src_r <= {pwdata[31:3], 3'b000};
      if (apb_wr_s && !busy_s && sel_dst_s) dst_r <= {pwdata[31:3], 3'b000};
      if (apb_wr_s && !busy_s && sel_len_s) len_r <= {pwdata[15:3], 3'b000};
      if (apb_wr_s && sel_ctrl_s) int_en_r <= pwdata[1];
      if (apb_wr_s && sel_stat_s) begin
        done_r <= done_r & ~pwdata[1];
        err_r  <= err_r & ~pwdata[2];
      end
      if (start_req_s) begin
        cur_src_r <= src_r;
        cur_dst_r <= dst_r;
        rem_r     <= len_r;
        if (len_r == 16'd0) done_r <= 1'b1;
      end
      if (ar_hs_s) begin
        blen_r     <= blen_s;
        cnt_r      <= 4'd0;
        err_pend_r <= 1'b0;
      end
      if (r_beat_s) begin
        cnt_r <= r_last_s ? 4'd0 : cnt_r + 4'd1;
        if (RRESP0 != 2'b00) err_pend_r <= 1'b1;
      end
      if (r_last_s) begin
        periph_rx_clr_r <= rd_hs_s;
        if (r_err_s) begin
          err_r  <= 1'b1;
          done_r <= 1'b1;
        end
      end
      if (w_beat_s) cnt_r <= (cnt_r == blen_r) ? 4'd0 : cnt_r + 4'd1;
      if (b_hs_s) begin
        periph_tx_clr_r <= wr_hs_s;
        if (BRESP0 != 2'b00) begin
          err_r  <= 1'b1;
          done_r <= 1'b1;
        end else begin
          cur_src_r <= cur_src_r + {16'd0, step_s};
          cur_dst_r <= cur_dst_r + {16'd0, step_s};
          rem_r     <= rem_next_s;
          if (rem_next_s == 16'd0) done_r <= 1'b1;
        end
      end
    end
  end

  // Burst staging buffer: filled by R beats, drained by W beats.
  always_ff @(posedge clk) begin
    if (r_beat_s) buf_r[cnt_r] <= RDATA0;
  end

  // APB read mux; unmapped offsets flag an error.
  always_comb begin
    prdata     = 32'd0;
    unmapped_s = 1'b0;
    case (paddr)
      8'h00:   prdata = src_r;
      8'h04:   prdata = dst_r;
      8'h08:   prdata = {16'd0, len_r};
      8'h0C:   prdata = {28'd0, wr_hs_s, rd_hs_s, int_en_r, 1'b0};
      8'h10:   prdata = {29'd0, err_r, done_r, busy_s};
      default: unmapped_s = 1'b1;
    endcase
  end

  assign pslverr       = apb_acc_s & unmapped_s;
  assign pready        = 1'b1;
  assign idle          = (state_r == ST_IDLE);
  assign INT           = done_r & int_en_r;
  assign periph_rx_clr = periph_rx_clr_r;
  assign periph_tx_clr = periph_tx_clr_r;

  assign ARID0    = 4'd0;
  assign ARADDR0  = cur_src_r;
  assign ARLEN0   = blen_s;
  assign ARSIZE0  = 2'd3;
  assign ARVALID0 = (state_r == ST_AR);
  assign RREADY0  = (state_r == ST_R);
  assign AWID0    = 4'd0;
  assign AWADDR0  = cur_dst_r;
  assign AWLEN0   = blen_r;
  assign AWSIZE0  = 2'd3;
  assign AWVALID0 = (state_r == ST_AW);
  assign WID0     = 4'd0;
  assign WDATA0   = buf_r[cnt_r];
  assign WSTRB0   = 8'hFF;
  assign WLAST0   = (state_r == ST_W) && (cnt_r == blen_r);
  assign WVALID0  = (state_r == ST_W);
  assign BREADY0  = (state_r == ST_B);
endmodule

// File: tb/tb_dma_axi64_engine.sv
// Self-checking bench for dma_axi64_engine: table of copy transfers plus directed corner cases,
// against a behavioural AXI memory slave and an APB master.
module tb_dma_axi64_engine;
  logic clk = 1'b0, reset, scan_en;
  logic idle, INT, periph_tx_req, periph_tx_clr, periph_rx_req, periph_rx_clr;
  logic pclken, psel, penable, pwrite, pslverr, pready;
  logic [7:0] paddr;
  logic [31:0] pwdata, prdata;
  logic [3:0] AWID0, AWLEN0, WID0, BID0, ARID0, ARLEN0, RID0;
  logic [31:0] AWADDR0, ARADDR0;
  logic [1:0] AWSIZE0, BRESP0, ARSIZE0, RRESP0;
  logic AWVALID0, AWREADY0, WLAST0, WVALID0, WREADY0, BVALID0, BREADY0;
  logic ARVALID0, ARREADY0, RLAST0, RVALID0, RREADY0;
  logic [63:0] WDATA0, RDATA0;
  logic [7:0] WSTRB0;

  always #5 clk = ~clk;

  dma_axi64_engine dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .idle(idle), .INT(INT),
    .periph_tx_req(periph_tx_req), .periph_tx_clr(periph_tx_clr),
    .periph_rx_req(periph_rx_req), .periph_rx_clr(periph_rx_clr),
    .pclken(pclken), .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pslverr(pslverr), .pready(pready),
    .AWID0(AWID0), .AWADDR0(AWADDR0), .AWLEN0(AWLEN0), .AWSIZE0(AWSIZE0),
    .AWVALID0(AWVALID0), .AWREADY0(AWREADY0),
    .WID0(WID0), .WDATA0(WDATA0), .WSTRB0(WSTRB0), .WLAST0(WLAST0),
    .WVALID0(WVALID0), .WREADY0(WREADY0),
    .BID0(BID0), .BRESP0(BRESP0), .BVALID0(BVALID0), .BREADY0(BREADY0),
    .ARID0(ARID0), .ARADDR0(ARADDR0), .ARLEN0(ARLEN0), .ARSIZE0(ARSIZE0),
    .ARVALID0(ARVALID0), .ARREADY0(ARREADY0),
    .RID0(RID0), .RDATA0(RDATA0), .RRESP0(RRESP0), .RLAST0(RLAST0),
    .RVALID0(RVALID0), .RREADY0(RREADY0)
  );

  int tests = 0, failed = 0, cyc = 0;
  int rd_left, wr_left, b_count, w_beats, proto_err, rx_clr_cnt, bresp_err_burst;
  int last_b_cyc, last_r_cyc, rx_clr_cyc;
  bit b_pending;
  logic [31:0] rd_addr, wr_addr;
  logic [31:0] ar_addr_q[$], aw_addr_q[$];
  logic [3:0] ar_len_q[$], aw_len_q[$];
  logic [63:0] wmem [logic [28:0]];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {a ^ 32'h5A5A_0000, ~a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // AXI memory slave: reads return pat(addr), writes land in wmem. Inputs change on negedge.
  initial begin
    ARREADY0 = 1'b0; RVALID0 = 1'b0; RDATA0 = 64'd0; RRESP0 = 2'd0; RLAST0 = 1'b0; RID0 = 4'd0;
    AWREADY0 = 1'b0; WREADY0 = 1'b1; BVALID0 = 1'b0; BRESP0 = 2'd0; BID0 = 4'd0;
    rd_left = 0; wr_left = 0; b_pending = 1'b0;
    forever begin
      @(negedge clk);
      if (periph_rx_clr) begin rx_clr_cnt++; rx_clr_cyc = cyc; end
      if (reset) begin
        rd_left = 0; wr_left = 0; b_pending = 1'b0;
        ARREADY0 = 1'b0; RVALID0 = 1'b0; AWREADY0 = 1'b0; BVALID0 = 1'b0;
      end else begin
        BVALID0 = 1'b0; BRESP0 = 2'd0;
        if (b_pending && BREADY0) begin
          BVALID0 = 1'b1;
          BRESP0 = (b_count == bresp_err_burst) ? 2'd2 : 2'd0;
          b_count++; b_pending = 1'b0; last_b_cyc = cyc;
        end
        RVALID0 = 1'b0; RLAST0 = 1'b0;
        if (rd_left > 0 && RREADY0) begin
          RVALID0 = 1'b1; RDATA0 = pat(rd_addr); RLAST0 = (rd_left == 1);
          rd_addr += 32'd8; rd_left--;
          if (rd_left == 0) last_r_cyc = cyc;
        end
        ARREADY0 = 1'b0;
        if (ARVALID0 && rd_left == 0) begin
          ARREADY0 = 1'b1;
          ar_addr_q.push_back(ARADDR0); ar_len_q.push_back(ARLEN0);
          if (ARSIZE0 !== 2'd3 || ARID0 !== 4'd0) proto_err++;
          rd_addr = ARADDR0; rd_left = int'(ARLEN0) + 1;
        end
        AWREADY0 = 1'b0;
        if (AWVALID0) begin
          AWREADY0 = 1'b1;
          aw_addr_q.push_back(AWADDR0); aw_len_q.push_back(AWLEN0);
          if (AWSIZE0 !== 2'd3 || AWID0 !== 4'd0) proto_err++;
          wr_addr = AWADDR0; wr_left = int'(AWLEN0) + 1;
        end else if (WVALID0) begin
          if (wr_left == 0 || WLAST0 !== (wr_left == 1) || WSTRB0 !== 8'hFF || WID0 !== 4'd0) proto_err++;
          wmem[wr_addr[31:3]] = WDATA0;
          wr_addr += 32'd8; w_beats++;
          if (wr_left > 0) wr_left--;
          if (wr_left == 0) b_pending = 1'b1;
        end
      end
    end
  end

  task automatic clear_logs();
    ar_addr_q.delete(); ar_len_q.delete(); aw_addr_q.delete(); aw_len_q.delete(); wmem.delete();
    b_count = 0; w_beats = 0; proto_err = 0; rx_clr_cnt = 0; bresp_err_burst = -1;
    last_b_cyc = -100; last_r_cyc = -100; rx_clr_cyc = -200;
  endtask

  task automatic apb_wr(input logic [7:0] a, input logic [31:0] d, output logic e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge clk); penable = 1'b1; #1; e = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_rd(input logic [7:0] a, output logic [31:0] d, output logic e);
    @(negedge clk); psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk); penable = 1'b1; #1; d = prdata; e = pslverr;
    @(negedge clk); psel = 1'b0; penable = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (!idle && n < 3000) begin @(negedge clk); n++; end
    chk({name, "_timeout"}, idle, 1'b1);
  endtask

  typedef struct {
    logic [31:0] src, dst; logic [15:0] len; logic int_en; int nb;
    logic [31:0] ar0, ar1, aw1; logic [3:0] len0, len1;
  } vec_t;
  vec_t vecs[4];

  initial begin
    logic [31:0] d; logic e; int bad, arv;
    vecs[0] = '{32'h1000, 32'h2000, 16'h0080, 1'b1, 1, 32'h1000, 32'h0,    32'h0,    4'd15, 4'd0};
    vecs[1] = '{32'h1000, 32'h2000, 16'h0088, 1'b0, 2, 32'h1000, 32'h1080, 32'h2080, 4'd15, 4'd0};
    vecs[2] = '{32'h0FF0, 32'h2000, 16'h0040, 1'b1, 2, 32'h0FF0, 32'h1000, 32'h2010, 4'd1,  4'd5};
    vecs[3] = '{32'h3000, 32'h4FE8, 16'h0100, 1'b0, 3, 32'h3000, 32'h3018, 32'h5000, 4'd2,  4'd15};

    scan_en = 1'b0; periph_tx_req = 1'b0; periph_rx_req = 1'b0;
    pclken = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'd0; pwdata = 32'd0;
    clear_logs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_idle", idle, 1'b1);
    chk("rst_int", INT, 1'b0);
    chk("rst_valids", {ARVALID0, AWVALID0, WVALID0, RREADY0, BREADY0}, 5'b0);
    chk("rst_clr", {periph_rx_clr, periph_tx_clr}, 2'b0);
    chk("rst_apb", {pready, pslverr}, 2'b10);
    apb_rd(8'h10, d, e); chk("rst_status", d, 32'h0);
    apb_rd(8'h08, d, e); chk("rst_len", d, 32'h0);

    apb_wr(8'h00, 32'h0000_1237, e); apb_rd(8'h00, d, e); chk("src_mask", d, 32'h1230);
    apb_wr(8'h08, 32'h0001_2345, e); apb_rd(8'h08, d, e); chk("len_mask", d, 32'h2340);
    apb_rd(8'h20, d, e); chk("unmapped_data", d, 32'h0); chk("unmapped_err", e, 1'b1);
    apb_rd(8'h0C, d, e); chk("mapped_err", e, 1'b0);

    // LEN=0: done immediately, FSM never leaves IDLE.
    clear_logs();
    apb_wr(8'h08, 32'h0, e);
    apb_wr(8'h0C, 32'h1, e);
    chk("len0_idle", idle, 1'b1);
    apb_rd(8'h10, d, e); chk("len0_status", d, 32'h2);
    chk("len0_no_ar", ar_addr_q.size(), 0);
    apb_wr(8'h10, 32'h2, e); apb_rd(8'h10, d, e); chk("len0_w1c", d, 32'h0);

    foreach (vecs[i]) begin
      clear_logs();
      apb_wr(8'h00, vecs[i].src, e);
      apb_wr(8'h04, vecs[i].dst, e);
      apb_wr(8'h08, {16'd0, vecs[i].len}, e);
      apb_wr(8'h0C, {30'd0, vecs[i].int_en, 1'b0}, e);
      apb_wr(8'h0C, {30'd0, vecs[i].int_en, 1'b1}, e);
      chk($sformatf("v%0d_arvalid_lat", i), ARVALID0, 1'b1);
      wait_idle($sformatf("v%0d", i));
      chk($sformatf("v%0d_done_lat", i), cyc, last_b_cyc + 1);
      chk($sformatf("v%0d_int", i), INT, vecs[i].int_en);
      chk($sformatf("v%0d_nbursts", i), ar_addr_q.size(), vecs[i].nb);
      chk($sformatf("v%0d_nbursts_aw", i), aw_addr_q.size(), vecs[i].nb);
      if (ar_addr_q.size() > 0) begin
        chk($sformatf("v%0d_ar0", i), {ar_addr_q[0], ar_len_q[0]}, {vecs[i].ar0, vecs[i].len0});
        chk($sformatf("v%0d_aw0", i), {aw_addr_q[0], aw_len_q[0]}, {vecs[i].dst, vecs[i].len0});
      end
      if (vecs[i].nb > 1 && ar_addr_q.size() > 1 && aw_addr_q.size() > 1) begin
        chk($sformatf("v%0d_ar1", i), {ar_addr_q[1], ar_len_q[1]}, {vecs[i].ar1, vecs[i].len1});
        chk($sformatf("v%0d_aw1", i), {aw_addr_q[1], aw_len_q[1]}, {vecs[i].aw1, vecs[i].len1});
      end
      bad = 0;
      for (int k = 0; k < int'(vecs[i].len) / 8; k++) begin
        logic [31:0] da, sa;
        da = vecs[i].dst + 32'(8 * k);
        sa = vecs[i].src + 32'(8 * k);
        if (!wmem.exists(da[31:3]) || wmem[da[31:3]] !== pat(sa)) bad++;
      end
      chk($sformatf("v%0d_data_bad", i), bad, 0);
      chk($sformatf("v%0d_wbeats", i), w_beats, int'(vecs[i].len) / 8);
      chk($sformatf("v%0d_proto", i), proto_err, 0);
      apb_rd(8'h10, d, e); chk($sformatf("v%0d_status", i), d, 32'h2);
      apb_wr(8'h10, 32'h2, e);
      chk($sformatf("v%0d_int_clr", i), INT, 1'b0);
    end

    // BRESP error on the first of two bursts aborts with err+done.
    clear_logs();
    bresp_err_burst = 0;
    apb_wr(8'h00, 32'h1000, e); apb_wr(8'h04, 32'h2000, e); apb_wr(8'h08, 32'h100, e);
    apb_wr(8'h0C, 32'h1, e);
    wait_idle("berr");
    apb_rd(8'h10, d, e); chk("berr_status", d, 32'h6);
    chk("berr_one_ar", ar_addr_q.size(), 1);
    apb_wr(8'h10, 32'h6, e); apb_rd(8'h10, d, e); chk("berr_w1c", d, 32'h0);

    // Writes while busy are dropped without an error response.
    clear_logs();
    apb_wr(8'h08, 32'h80, e);
    apb_wr(8'h0C, 32'h1, e);
    apb_wr(8'h00, 32'hDEAD_0000, e); chk("busy_wr_err", e, 1'b0);
    apb_rd(8'h10, d, e); chk("busy_bit", d[0], 1'b1);
    wait_idle("busy");
    apb_rd(8'h00, d, e); chk("busy_src_kept", d, 32'h1000);
    apb_wr(8'h10, 32'h6, e);

`ifdef DMA_AXI64_PERIPH_HS_EN
    // Read-side handshake: AR is held off until periph_rx_req.
    clear_logs();
    periph_tx_req = 1'b1;
    apb_wr(8'h0C, 32'h4, e);
    apb_wr(8'h0C, 32'h5, e);
    arv = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (ARVALID0) arv++; end
    chk("hs_no_ar", arv, 0);
    chk("hs_busy", idle, 1'b0);
    periph_rx_req = 1'b1;
    wait_idle("hs");
    chk("hs_ar_count", ar_addr_q.size(), 1);
    chk("hs_rx_clr_cnt", rx_clr_cnt, 1);
    chk("hs_rx_clr_lat", rx_clr_cyc, last_r_cyc + 1);
    periph_rx_req = 1'b0;
    apb_wr(8'h0C, 32'h0, e); apb_wr(8'h10, 32'h6, e);
`else
    apb_wr(8'h0C, 32'hE, e); apb_rd(8'h0C, d, e); chk("ctrl_hs_ro", d, 32'h2);
    apb_wr(8'h0C, 32'h0, e);
`endif

    // Reset mid-transfer: everything returns to reset state at once.
    clear_logs();
    apb_wr(8'h0C, 32'h3, e);
    repeat (5) @(negedge clk);
    chk("mid_busy", idle, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_idle", idle, 1'b1);
    chk("mid_rst_valids", {ARVALID0, AWVALID0, WVALID0, RREADY0, BREADY0, INT}, 6'b0);
    apb_rd(8'h10, d, e); chk("mid_rst_status", d, 32'h0);
    apb_rd(8'h00, d, e); chk("mid_rst_src", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget, %0d tests run", tests);
    $fatal(1);
  end
endmodule
